cv_stream_sequencer: RTL and testbench

Memory-side initiator for the 3x3 convolution core. On `start` it latches a layer configuration, then issues the core's `load_weight` / `load_input` / `store_output` commands. It streams weights, optional bias and input activations from a 1-cycle-latency SRAM read port into the core's `din` stream, and drains the core's ReLU'd outputs into an SRAM write port. It sits between the layer controller and the convolution core, one instance per core.

---
 rtl/cv_stream_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_cv_stream_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_stream_sequencer.sv
// cv_stream_sequencer: memory-side initiator for the 3x3 convolution core.
// Latches a layer configuration on start, streams weights / bias / inputs from a
// 1-cycle-latency SRAM read port into the core din stream, then drains the core
// outputs into an SRAM write port.
module cv_stream_sequencer #(
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          cfg_has_bias,
  input  logic [4:0]    cfg_K,
  input  logic [10:0]   cfg_Iext,
  input  logic [10:0]   cfg_Oext,
  input  logic [7:0]    cfg_Hext,
  input  logic [7:0]    cfg_Wext,
  input  logic [AW-1:0] cfg_w_base,
  input  logic [AW-1:0] cfg_i_base,
  input  logic [AW-1:0] cfg_o_base,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [15:0]   mem_rd_data,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_wr_addr,
  output logic [15:0]   mem_wr_data,
  output logic          core_load_weight,
  output logic          core_load_input,
  output logic          core_store_output,
  output logic          core_has_bias,
  output logic          core_din_valid,
  output logic [15:0]   core_din_data,
  input  logic          core_calc_done,
  input  logic          core_dout_valid,
  input  logic [15:0]   core_dout_data,
  output logic          core_dout_ready
);

  typedef enum logic [3:0] {
    StIdle, StW, StB, StGap, StI, StWaitC, StDrain, StFlush, StDone
  } state_e;

  localparam logic [31:0] MaxCount = 32'd32768;

  state_e        r_state;
  logic [16:0]   r_nw, r_nb, r_ni, r_no;
  logic [16:0]   r_cnt;
  logic [1:0]    r_gap;
  logic          r_seen;
  logic [AW-1:0] r_i_base, r_o_base;
  logic          r_has_bias;
  logic          r_rd_en, r_din_valid;
  logic [AW-1:0] r_rd_addr;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [15:0]   r_wr_data;
  logic          r_load_w, r_load_i, r_store, r_ready, r_done, r_cfg_err;

  logic [31:0]   w_h_span, w_w_span, w_nw_full, w_ni_full, w_no_full;
  logic          w_cfg_bad;

  // Full-width derived counts so oversize layers are caught before truncation
  always_comb begin
    w_h_span  = 32'(cfg_Hext) - 32'(cfg_K) + 32'd1;
    w_w_span  = 32'(cfg_Wext) - 32'(cfg_K) + 32'd1;
    w_nw_full = 32'(cfg_Oext) * 32'(cfg_Iext) * 32'(cfg_K) * 32'(cfg_K);
    w_ni_full = 32'(cfg_Iext) * 32'(cfg_Hext) * 32'(cfg_Wext);
    w_no_full = 32'(cfg_Oext) * w_h_span * w_w_span;
    w_cfg_bad = (cfg_K == '0) || (cfg_Iext == '0) || (cfg_Oext == '0) ||
                (cfg_Hext == '0) || (cfg_Wext == '0) ||
                (32'(cfg_K) > 32'(cfg_Hext)) || (32'(cfg_K) > 32'(cfg_Wext)) ||
                (w_nw_full > MaxCount) || (w_ni_full > MaxCount) || (w_no_full > MaxCount);
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_nw        <= '0;
      r_nb        <= '0;
      r_ni        <= '0;
      r_no        <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_seen      <= 1'b0;
      r_i_base    <= '0;
      r_o_base    <= '0;
      r_has_bias  <= 1'b0;
      r_rd_en     <= 1'b0;
      r_din_valid <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_load_w    <= 1'b0;
      r_load_i    <= 1'b0;
      r_store     <= 1'b0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_load_w    <= 1'b0;
      r_load_i    <= 1'b0;
      r_store     <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_din_valid <= r_rd_en;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (w_cfg_bad) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_nw       <= w_nw_full[16:0];
              r_nb       <= cfg_has_bias ? 17'(cfg_Oext) : 17'd0;
              r_ni       <= w_ni_full[16:0];
              r_no       <= w_no_full[16:0];
              r_has_bias <= cfg_has_bias;
              r_i_base   <= cfg_i_base;
              r_o_base   <= cfg_o_base;
              r_cnt      <= '0;
              r_rd_en    <= 1'b1;
              r_rd_addr  <= cfg_w_base;
              r_load_w   <= 1'b1;
              r_state    <= StW;
            end
          end
        end
        StW: begin
          if (r_cnt == r_nw - 17'd1) begin
            r_cnt <= '0;
            if (r_has_bias) begin
              // Bias sits right after the weights, so the address just keeps counting
              r_rd_addr <= r_rd_addr + AW'(1);
              r_state   <= StB;
            end else begin
              r_rd_en <= 1'b0;
              r_gap   <= '0;
              r_state <= StGap;
            end
          end else begin
            r_cnt     <= r_cnt + 17'd1;
            r_rd_addr <= r_rd_addr + AW'(1);
          end
        end
        StB: begin
          if (r_cnt == r_nb - 17'd1) begin
            r_cnt     <= '0;
            r_rd_addr <= r_i_base;
            r_state   <= StI;
          end else begin
            r_cnt     <= r_cnt + 17'd1;
            r_rd_addr <= r_rd_addr + AW'(1);
          end
        end
        StGap: begin
          if (r_gap == 2'd2) begin
            r_load_i  <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_i_base;
            r_cnt     <= '0;
            r_state   <= StI;
          end else begin
            r_gap <= r_gap + 2'd1;
          end
        end
        StI: begin
          if (r_cnt == r_ni - 17'd1) begin
            r_rd_en <= 1'b0;
            r_seen  <= 1'b0;
            r_state <= StWaitC;
          end else begin
            r_cnt     <= r_cnt + 17'd1;
            r_rd_addr <= r_rd_addr + AW'(1);
          end
        end
        StWaitC: begin
          // One extra cycle after calc_done is observed before store_output
          if (r_seen) begin
            r_store <= 1'b1;
            r_ready <= 1'b1;
            r_cnt   <= '0;
            r_state <= StDrain;
          end else if (core_calc_done) begin
            r_seen <= 1'b1;
          end
        end
        StDrain: begin
          if (core_dout_valid) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_o_base + AW'(r_cnt);
            r_wr_data <= core_dout_data;
            if (r_cnt == r_no - 17'd1) begin
              r_ready <= 1'b0;
              r_state <= StFlush;
            end else begin
              r_cnt <= r_cnt + 17'd1;
            end
          end
        end
        StFlush: begin
          if (!core_dout_valid) begin
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Output mapping; din data is gated so it reads zero outside valid beats
  always_comb begin
    busy              = (r_state != StIdle);
    done              = r_done;
    cfg_err           = r_cfg_err;
    mem_rd_en         = r_rd_en;
    mem_rd_addr       = r_rd_addr;
    mem_wr_en         = r_wr_en;
    mem_wr_addr       = r_wr_addr;
    mem_wr_data       = r_wr_data;
    core_load_weight  = r_load_w;
    core_load_input   = r_load_i;
    core_store_output = r_store;
    core_has_bias     = r_has_bias;
    core_din_valid    = r_din_valid;
    core_din_data     = r_din_valid ? mem_rd_data : 16'h0000;
    core_dout_ready   = r_ready;
  end

endmodule

// File: tb/tb_cv_stream_sequencer.sv
// Scoreboard bench for cv_stream_sequencer: stimulus pushes expected din beats
// and SRAM writes into queues; a negedge monitor pops and compares them.
module tb_cv_stream_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cfg_has_bias;
  logic [4:0]  cfg_K;
  logic [10:0] cfg_Iext, cfg_Oext;
  logic [7:0]  cfg_Hext, cfg_Wext;
  logic [15:0] cfg_w_base, cfg_i_base, cfg_o_base;
  logic        busy, done, cfg_err;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr, mem_rd_data;
  logic        mem_wr_en;
  logic [15:0] mem_wr_addr, mem_wr_data;
  logic        core_load_weight, core_load_input, core_store_output, core_has_bias;
  logic        core_din_valid;
  logic [15:0] core_din_data;
  logic        core_calc_done, core_dout_valid, core_dout_ready;
  logic [15:0] core_dout_data;

  cv_stream_sequencer #(.AW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_has_bias(cfg_has_bias),
    .cfg_K(cfg_K), .cfg_Iext(cfg_Iext), .cfg_Oext(cfg_Oext),
    .cfg_Hext(cfg_Hext), .cfg_Wext(cfg_Wext),
    .cfg_w_base(cfg_w_base), .cfg_i_base(cfg_i_base), .cfg_o_base(cfg_o_base),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .core_load_weight(core_load_weight), .core_load_input(core_load_input),
    .core_store_output(core_store_output), .core_has_bias(core_has_bias),
    .core_din_valid(core_din_valid), .core_din_data(core_din_data),
    .core_calc_done(core_calc_done), .core_dout_valid(core_dout_valid),
    .core_dout_data(core_dout_data), .core_dout_ready(core_dout_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: word at address a holds a ^ 16'h5A5A, one cycle read latency
  always @(posedge clk) mem_rd_data <= mem_rd_en ? (mem_rd_addr ^ 16'h5A5A) : 16'h0000;

  typedef struct { logic [15:0] data; int cyc; } din_t;
  typedef struct { logic [15:0] addr; logic [15:0] data; int cyc; } wr_t;
  din_t exp_din[$];
  wr_t  exp_wr[$];

  int checks = 0, failures = 0;
  int n_lw = 0, n_li = 0, n_so = 0, n_done = 0, n_err = 0, n_wr = 0, n_rd = 0, n_busy = 0;
  int lw_cyc = 0, li_cyc = 0, so_cyc = 0, done_cyc = 0, err_cyc = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops scoreboard entries whenever the DUT presents a beat
  always @(negedge clk) begin
    din_t d;
    wr_t  w;
    if (core_din_valid) begin
      if (exp_din.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL din_unexpected actual=%0h required=none (cycle %0d)", core_din_data, cyc);
      end else begin
        d = exp_din.pop_front();
        check("din_data", core_din_data, d.data);
        check("din_cycle", cyc, d.cyc);
      end
    end
    if (mem_wr_en) begin
      n_wr++;
      if (exp_wr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected actual=%0h required=none (cycle %0d)", mem_wr_addr, cyc);
      end else begin
        w = exp_wr.pop_front();
        check("wr_addr", mem_wr_addr, w.addr);
        check("wr_data", mem_wr_data, w.data);
        check("wr_cycle", cyc, w.cyc);
      end
    end
    if (core_load_weight)  begin n_lw++;   lw_cyc = cyc;   end
    if (core_load_input)   begin n_li++;   li_cyc = cyc;   end
    if (core_store_output) begin n_so++;   so_cyc = cyc;   end
    if (done)              begin n_done++; done_cyc = cyc; end
    if (cfg_err)           begin n_err++;  err_cyc = cyc;  end
    if (mem_rd_en) n_rd++;
    if (busy)      n_busy++;
  end

  // Layer used throughout: K=3 Iext=1 Oext=2 H=W=4 -> NW=18 NB=2 NI=16 NO=8
  task automatic set_cfg(input bit hb, input logic [7:0] h, input logic [15:0] wb);
    cfg_has_bias = hb;
    cfg_K = 5'd3; cfg_Iext = 11'd1; cfg_Oext = 11'd2;
    cfg_Hext = h; cfg_Wext = 8'd4;
    cfg_w_base = wb; cfg_i_base = 16'h0200; cfg_o_base = 16'h0300;
  endtask

  // Expected din beats for start seen in cycle s
  task automatic push_din(input bit hb, input logic [15:0] wb, input int s);
    logic [15:0] a;
    int first_i;
    for (int k = 0; k < 18; k++) begin
      a = wb + 16'(k);
      exp_din.push_back('{data: a ^ 16'h5A5A, cyc: s + 2 + k});
    end
    if (hb) begin
      for (int j = 0; j < 2; j++) begin
        a = wb + 16'd18 + 16'(j);
        exp_din.push_back('{data: a ^ 16'h5A5A, cyc: s + 20 + j});
      end
    end
    first_i = hb ? s + 22 : s + 23;
    for (int j = 0; j < 16; j++) begin
      a = 16'h0200 + 16'(j);
      exp_din.push_back('{data: a ^ 16'h5A5A, cyc: first_i + j});
    end
  endtask

  task automatic run_layer(input bit hb, input int extra, input bit poke, input logic [15:0] wb);
    int s, c, d, tmo, lw0, li0, so0, do0, wr0;
    set_cfg(hb, 8'd4, wb);
    @(negedge clk);
    lw0 = n_lw; li0 = n_li; so0 = n_so; do0 = n_done; wr0 = n_wr;
    s = cyc;
    start = 1'b1;
    push_din(hb, wb, s);
    @(negedge clk);
    start = 1'b0;
    tmo = 0;
    while (exp_din.size() != 0 && tmo < 200) begin @(negedge clk); tmo++; end
    check("din_stream_drained", exp_din.size(), 0);
    exp_din.delete();
    check("load_weight_cycle", lw_cyc, s + 1);
    check("load_weight_count", n_lw - lw0, 1);
    check("load_input_count", n_li - li0, hb ? 0 : 1);
    if (!hb) check("load_input_cycle", li_cyc, s + 22);
    check("core_has_bias", core_has_bias, hb);
    check("busy_running", busy, 1);
    // Core signals calc_done; store_output must follow two cycles later
    @(negedge clk);
    @(negedge clk);
    c = cyc;
    core_calc_done = 1'b1;
    @(negedge clk);
    core_calc_done = 1'b0;
    tmo = 0;
    while (n_so == so0 && tmo < 20) begin @(negedge clk); tmo++; end
    check("store_count", n_so - so0, 1);
    check("store_cycle", so_cyc, c + 2);
    @(negedge clk);
    @(negedge clk);
    d = cyc;
    for (int k = 0; k < 8 + extra; k++) begin
      core_dout_valid = 1'b1;
      core_dout_data  = 16'hA000 + 16'(k);
      if (k < 8) begin
        exp_wr.push_back('{addr: 16'h0300 + 16'(k), data: 16'hA000 + 16'(k), cyc: d + k + 1});
        check("dout_ready", core_dout_ready, 1);
      end
      start = (poke && k == 3);
      @(negedge clk);
    end
    core_dout_valid = 1'b0;
    start = 1'b0;
    tmo = 0;
    while (n_done == do0 && tmo < 50) begin @(negedge clk); tmo++; end
    check("done_cycle", done_cyc, d + 9 + extra);
    repeat (3) @(negedge clk);
    check("done_count", n_done - do0, 1);
    check("write_count", n_wr - wr0, 8);
    check("writes_pending", exp_wr.size(), 0);
    check("load_weight_total", n_lw - lw0, 1);
    check("busy_after_done", busy, 0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_flags"}, {busy, done, cfg_err, mem_rd_en, mem_wr_en, core_load_weight,
                             core_load_input, core_store_output, core_has_bias,
                             core_din_valid, core_dout_ready}, 0);
    check({name, "_buses"}, mem_rd_addr | mem_wr_addr | mem_wr_data | core_din_data, 0);
  endtask

  initial begin
    int s, rd0, bz0, lw0, li0, so0, er0, wr0;
    rst_n = 1'b0;
    start = 1'b0;
    core_calc_done = 1'b0;
    core_dout_valid = 1'b0;
    core_dout_data = 16'h0000;
    set_cfg(1'b1, 8'd4, 16'h0100);
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_layer(1'b1, 0, 1'b0, 16'h0100);  // bias layer
    run_layer(1'b0, 0, 1'b0, 16'h0100);  // no bias, gap before inputs
    run_layer(1'b1, 3, 1'b0, 16'h0100);  // over-drain

    // Bad config: K > Hext
    set_cfg(1'b0, 8'd2, 16'h0100);
    @(negedge clk);
    rd0 = n_rd; bz0 = n_busy; lw0 = n_lw; li0 = n_li; so0 = n_so; er0 = n_err; wr0 = n_wr;
    s = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("cfg_err_count", n_err - er0, 1);
    check("cfg_err_cycle", err_cyc, s + 1);
    check("bad_cfg_reads", n_rd - rd0, 0);
    check("bad_cfg_busy", n_busy - bz0, 0);
    check("bad_cfg_cmds", (n_lw - lw0) + (n_li - li0) + (n_so - so0) + (n_wr - wr0), 0);

    // Reset while weight word 10 is being read
    set_cfg(1'b1, 8'd4, 16'h0100);
    @(negedge clk);
    s = cyc;
    start = 1'b1;
    push_din(1'b1, 16'h0100, s);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("reads_before_abort", mem_rd_addr, 16'h010A);
    #2 rst_n = 1'b0;
    #1 check_quiet("abort");
    exp_din.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_abort", {busy, mem_rd_en, core_din_valid}, 0);
    run_layer(1'b1, 0, 1'b0, 16'hFFF0);  // restart; weight/bias addresses wrap

    run_layer(1'b0, 0, 1'b1, 16'h0100);  // start pulsed during drain

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
